// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit: op codes,
// FSM states, the divide-by-zero quotient and op classification helpers.
package ex_muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    function automatic logic op_iter(input logic [2:0] op);
        return (op != OP_MTHI) && (op != OP_MTLO);
    endfunction

    function automatic logic op_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_signed(input logic [2:0] op);
        return (op != OP_MULTU) && (op != OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: one shift-add multiply step or one restoring-divide
// step per cycle on a double-width accumulator, plus the iteration counter.
module muldiv_iter_core
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   ma,
    input  logic [WIDTH-1:0]   mb,
    output logic               last,
    output logic [2*WIDTH-1:0] nxt
);
    localparam int CW = $clog2(ITER);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               div_q;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;
    logic               ge;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    // The partial remainder is always below the divisor, so a successful
    // trial subtraction fits back into WIDTH bits.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ge      = shifted >= {1'b0, opnd};
        diff    = shifted[WIDTH-1:0] - opnd;
        if (!div_q)
            nxt = {sum, acc[WIDTH-1:1]};
        else if (ge)
            nxt = {diff, acc[WIDTH-2:0], 1'b1};
        else
            nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    assign last = (cnt == CW'(ITER-1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc   <= '0;
            opnd  <= '0;
            div_q <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            acc   <= {{WIDTH{1'b0}}, (is_div ? ma : mb)};
            opnd  <= is_div ? mb : ma;
            div_q <= is_div;
            cnt   <= '0;
        end else if (step) begin
            acc   <= nxt;
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage multiply/divide unit owning HI/LO, with FSM, sign fix-up,
// Flush and Stall. Define EX_MULDIV_FAST_MULT_EN for single-cycle multiplies.
module ex_muldiv_unit
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             Stall
);
    logic [1:0]         state;
    logic [2:0]         op_q;
    logic               neg_res, neg_rem, div0;

    logic               accept, start_iter, load, step, last;
    logic               sa, sb;
    logic [WIDTH-1:0]   ma, mb;
    logic [2*WIDTH-1:0] hilo, core_nxt, prod_s;
    logic [WIDTH-1:0]   q_mag, r_mag, q_fix, r_fix;

    function automatic logic [2*WIDTH-1:0] mac(input logic [2:0] op,
                                               input logic [2*WIDTH-1:0] acc,
                                               input logic [2*WIDTH-1:0] p);
        case (op)
            OP_MADD: return acc + p;
            OP_MSUB: return acc - p;
            default: return p;
        endcase
    endfunction

    assign hilo       = {Hi, Lo};
    assign accept     = (state == ST_IDLE || state == ST_DONE) && Start && !Flush;
    assign start_iter = accept && op_iter(Op);
    assign Stall      = (state == ST_BUSY) || start_iter;
    assign Busy       = (state == ST_BUSY);
    assign Done       = (state == ST_DONE);
    assign step       = (state == ST_BUSY) && !Flush;

    assign sa = A[WIDTH-1] && op_signed(Op);
    assign sb = B[WIDTH-1] && op_signed(Op);
    assign ma = sa ? -A : A;
    assign mb = sb ? -B : B;

`ifdef EX_MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] xa, xb, fprod;
    // Sign-extended operands give the signed product modulo 2^(2*WIDTH).
    assign xa    = {{WIDTH{sa}}, A};
    assign xb    = {{WIDTH{sb}}, B};
    assign fprod = xa * xb;
    assign load  = start_iter && op_div(Op);
`else
    assign load  = start_iter;
`endif

    muldiv_iter_core #(.WIDTH(WIDTH), .ITER(ITER)) u_core (
        .Clk    (Clk),
        .Rst    (Rst),
        .load   (load),
        .step   (step),
        .is_div (op_div(Op)),
        .ma     (ma),
        .mb     (mb),
        .last   (last),
        .nxt    (core_nxt)
    );

    assign prod_s = neg_res ? -core_nxt : core_nxt;
    assign q_mag  = core_nxt[WIDTH-1:0];
    assign r_mag  = core_nxt[2*WIDTH-1:WIDTH];
    // A zero divisor leaves |A| as the remainder, so the sign fix restores A.
    assign q_fix  = div0 ? WIDTH'(DIV0_LO) : (neg_res ? -q_mag : q_mag);
    assign r_fix  = neg_rem ? -r_mag : r_mag;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= ST_IDLE;
            Hi      <= '0;
            Lo      <= '0;
            op_q    <= OP_MULT;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
        end else begin
            case (state)
                ST_BUSY: begin
                    if (Flush) begin
                        state <= ST_IDLE;
                    end else if (last) begin
                        state <= ST_DONE;
                        if (op_div(op_q)) begin
                            Lo <= q_fix;
                            Hi <= r_fix;
                        end else begin
                            {Hi, Lo} <= mac(op_q, hilo, prod_s);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    if (accept) begin
                        if (Op == OP_MTHI) begin
                            Hi <= A;
                        end else if (Op == OP_MTLO) begin
                            Lo <= A;
                        end else begin
                            op_q    <= Op;
                            neg_res <= sa ^ sb;
                            neg_rem <= sa;
                            div0    <= (B == '0);
`ifdef EX_MULDIV_FAST_MULT_EN
                            if (op_div(Op)) begin
                                state <= ST_BUSY;
                            end else begin
                                {Hi, Lo} <= mac(Op, hilo, fprod);
                                state    <= ST_DONE;
                            end
`else
                            state <= ST_BUSY;
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit (default build: all ops iterative).
`timescale 1ns/1ps
module tb_ex_muldiv_unit;
    import ex_muldiv_pkg::*;

    logic        Clk = 1'b0, Rst = 1'b1, Start = 1'b0, Flush = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] A = '0, B = '0;
    logic [31:0] Hi, Lo;
    logic        Busy, Done, Stall;

    int          checks = 0, failures = 0;
    logic [63:0] sb[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] mon_e;

    always #5 Clk = ~Clk;

    ex_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B), .Flush(Flush),
        .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .Stall(Stall)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] hl);
        logic [63:0] sp, up;
        sp = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
        up = {32'h0, a} * {32'h0, b};
        case (op)
            OP_MULT:  return sp;
            OP_MULTU: return up;
            OP_MADD:  return hl + sp;
            OP_MSUB:  return hl - sp;
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            end
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return hl;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        Op = op; A = a; B = b; Start = 1'b1;
        if (op == OP_MTHI) m_hi = a;
        else if (op == OP_MTLO) m_lo = a;
        else begin
            e = ref_res(op, a, b, {m_hi, m_lo});
            sb.push_back(e);
            {m_hi, m_lo} = e;
        end
    endtask

    // Counts Stall cycles from the issue cycle until Done, bounded.
    task automatic wait_done(input int exp_stall);
        int n = 0, st = 0;
        bit seen = 1'b0;
        while (n < 80 && !seen) begin
            @(negedge Clk);
            if (Stall) st++;
            if (Done && n > 0) seen = 1'b1;
            tick();
            Start = 1'b0;
            n++;
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("stall_cycles", 64'(st), 64'(exp_stall));
        chk("done_pulse", 64'(Done), 64'd0);
    endtask

    always @(negedge Clk) begin
        if (!Rst && Done) begin
            chk("sb_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("hi", 64'(Hi), 64'(mon_e[63:32]));
                chk("lo", 64'(Lo), 64'(mon_e[31:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        tick(); tick();
        Rst = 1'b0;
        @(negedge Clk);
        chk("rst_hi", 64'(Hi), 64'd0);
        chk("rst_lo", 64'(Lo), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_stall", 64'(Stall), 64'd0);
        tick();

        // Reset in the middle of a multiply
        drive(OP_MTHI, 32'h1234, 32'h0);
        #1 chk("mthi_stall", 64'(Stall), 64'd0);
        tick(); Start = 1'b0;
        chk("mthi_hi", 64'(Hi), 64'h1234);
        Op = OP_MULT; A = 32'd5; B = 32'd6; Start = 1'b1;
        tick(); Start = 1'b0;
        repeat (5) tick();
        chk("mid_busy", 64'(Busy), 64'd1);
        Rst = 1'b1; tick(); tick(); Rst = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge Clk);
        chk("rst2_hi", 64'(Hi), 64'd0);
        chk("rst2_lo", 64'(Lo), 64'd0);
        chk("rst2_busy", 64'(Busy), 64'd0);
        chk("rst2_stall", 64'(Stall), 64'd0);
        tick();

        drive(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        #1 chk("issue_stall", 64'(Stall), 64'd1);
        wait_done(33);
        drive(OP_DIV, 32'hFFFF_FFF9, 32'd2);            wait_done(33);
        drive(OP_DIVU, 32'd7, 32'd0);                   wait_done(33);
        drive(OP_DIV, 32'hFFFF_FFF9, 32'd0);            wait_done(33);
        drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);    wait_done(33);
        drive(OP_DIV, 32'd100, 32'hFFFF_FFF9);          wait_done(33);

        drive(OP_MTHI, 32'd5, 32'd0);  tick(); Start = 1'b0;
        drive(OP_MTLO, 32'h10, 32'd0); tick(); Start = 1'b0;
        chk("mtlo_lo", 64'(Lo), 64'h10);
        drive(OP_MADD, 32'd2, 32'd3);                   wait_done(33);
        drive(OP_MSUB, 32'hFFFF_FFFE, 32'd5);           wait_done(33);

        for (int i = 0; i < 6; i++) begin
            drive((i < 4) ? 3'(i) : 3'(i + 2), $urandom, $urandom);
            wait_done(33);
        end

        // Flush together with Start in IDLE discards the Start
        Flush = 1'b1; Op = OP_DIVU; A = 32'd9; B = 32'd3; Start = 1'b1;
        #1 chk("flush_start_stall", 64'(Stall), 64'd0);
        tick();
        chk("flush_start_busy", 64'(Busy), 64'd0);
        Op = OP_MTHI; A = 32'hDEAD;
        tick(); Flush = 1'b0; Start = 1'b0;
        chk("flush_mthi_hi", 64'(Hi), 64'(m_hi));

        // Flush at iteration 10 of a MULTU
        Op = OP_MULTU; A = 32'd123; B = 32'd456; Start = 1'b1;
        tick(); Start = 1'b0;
        repeat (10) tick();
        chk("flush_pre_busy", 64'(Busy), 64'd1);
        Flush = 1'b1;
        tick(); Flush = 1'b0;
        chk("flush_busy", 64'(Busy), 64'd0);
        chk("flush_done", 64'(Done), 64'd0);
        chk("flush_hilo", {Hi, Lo}, {m_hi, m_lo});
        drive(OP_MULTU, 32'd9, 32'd11);
        #1 chk("restart_stall", 64'(Stall), 64'd1);
        wait_done(33);

        // Back-to-back issue in the DONE cycle
        drive(OP_MULTU, 32'd3, 32'd5);
        repeat (33) begin tick(); Start = 1'b0; end
        chk("b2b_in_done", 64'(Done), 64'd1);
        drive(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_done(33);
        chk("b2b_hilo", {Hi, Lo}, 64'h1_FFFF_FFFE);

        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Execute-stage multi-cycle multiply/divide unit.
- Consumes the operand and operation fields latched by the ID/EX pipeline register.
- Owns the architectural HI/LO registers.
- Raises Stall so hazard logic freezes PC, IF/ID and ID/EX while an iterative operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, 32, iterations per multiply/divide; must equal WIDTH.

Ports:
- Clk  input  1  pipeline clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  issue request; qualifies Op, A and B.
- Op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
- A  input  32  rs operand (ReadData1 from ID/EX).
- B  input  32  rt operand (ReadData2 from ID/EX).
- Flush  input  1  abort the in-flight operation (branch/jump squash).
- Hi  output  32  HI register.
- Lo  output  32  LO register.
- Busy  output  1  high in the BUSY state.
- Done  output  1  one-cycle pulse: HI/LO were just updated by an iterative operation.
- Stall  output  1  combinational pipeline-hold request.

Behaviour:
- Reset: Hi=0, Lo=0, Busy=0, Done=0, state=IDLE, iteration counter=0.
- Rst overrides everything, including a mid-operation state.
- States: IDLE, BUSY, DONE.
- IDLE, Start with Op 4/5: write Hi=A (MTHI) or Lo=A (MTLO) at the next edge; stay IDLE; Stall=0; Done=0.
- IDLE, Start with Op 0-3 or 6-7:
  - Latch operand magnitudes, result-sign flags and Op.
  - Counter=0; next state BUSY.
  - Stall=1 in this same cycle (combinational).
- BUSY, multiply: one shift-add step per cycle on a 64-bit accumulator.
- BUSY, divide: one restoring-division step per cycle.
- BUSY exit: after ITER cycles, at the edge where counter==ITER-1, write HI/LO and move to DONE.
- DONE: Done=1, Stall=0, Busy=0 for one cycle, then IDLE.
- A Start in DONE is handled exactly as in IDLE (back-to-back issue).
- Latency: Hi/Lo valid 33 cycles after the edge that accepts Start; Stall is high for exactly 33 cycles.
- Results:
  - MULT/MULTU: {Hi,Lo} = product; signed product is the two's complement of the magnitude product when the signs differ.
  - MADD/MSUB: {Hi,Lo} = {Hi,Lo} ± signed product, modulo 2^64, using Hi/Lo as sampled at Start.
  - DIV/DIVU: Lo = quotient, Hi = remainder.
  - Signed division: quotient truncates toward zero; remainder takes the sign of A.
- Divide by zero: Lo=32'hFFFFFFFF, Hi=A; same 33-cycle latency.
- Signed overflow, 0x80000000 / -1: Lo=0x80000000, Hi=0.
- Start while BUSY: ignored (the pipeline is stalled, so Start is held and reissued in DONE/IDLE).
- Flush:
  - In BUSY: state to IDLE at the next edge; HI/LO unchanged; no Done.
  - In DONE: no effect (HI/LO already committed).
  - Together with Start in IDLE: the Start is discarded.
- Stall = (state==BUSY) | (state∈{IDLE,DONE} & Start & Op iterative & ~Flush).

Optional Feature:
- Macro: EX_MULDIV_FAST_MULT_EN.
- Defined: Op 0,1,6,7 use a single-cycle 64-bit multiplier; result is written at the edge after Start, then DONE.
  - Stall is high only in the Start cycle; total latency 1 cycle.
  - Divide is still iterative.
- Undefined: all multiply ops are iterative, as above.

Decomposition:
- Shared package ex_muldiv_pkg: Op encodings (OP_MULT..OP_MSUB), state encoding, DIV0_LO constant.
- One sub-module, muldiv_iter_core: holds the accumulator, counter and step logic for multiply and divide.
- The top level owns the FSM, HI/LO, sign fix-up, Flush and Stall.

Test Plan:
- Rst high for 2 cycles mid-BUSY -> Hi=0, Lo=0, Busy=0, Stall=0 the following cycle.
- MULT A=-3 (0xFFFFFFFD), B=7 -> Stall high 33 cycles, Done pulse; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- DIV A=-7, B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); DIVU A=7, B=0 -> Lo=0xFFFFFFFF, Hi=7.
- MTHI A=5, then MADD A=2, B=3 with Lo=0x10 -> Hi=5, Lo=0x16 after Done.
- MULTU started, Flush at iteration 10 -> IDLE next cycle, no Done, HI/LO retain prior values; a new Start is accepted the cycle after.
- Back-to-back MULTU 0xFFFFFFFF×2 issued in DONE -> second result Hi=1, Lo=0xFFFFFFFE, 33 cycles later.
